snake_body: RTL and testbench

Maintains the snake's body as a packed segment vector and advances it one board cell per move request. It sits directly upstream of the board writer stage: its `snake_out` vector is that stage's `snake_in`, and its `done` pulse is the trigger for a board rewrite. Per move it applies the requested direction, checks the new head against the body over several cycles, then shifts the body. It also grows the snake on request and latches a sticky game-over on self-collision.

---
 rtl/snake_body.sv | 140 ++++++++++++++
 tb/tb_snake_body.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake segment vector with per-move self-collision scan and shift
module snake_body #(
   parameter int         MAX_LEN  = 225,
   parameter int         INIT_LEN = 3,
   parameter logic [3:0] INIT_X   = 4'd5,
   parameter logic [3:0] INIT_Y   = 4'd7
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 step,
   input  logic [1:0]           dir,
   input  logic                 grow,
   output logic [8*MAX_LEN-1:0] snake_out,
   output logic [7:0]           length,
   output logic [3:0]           head_x,
   output logic [3:0]           head_y,
   output logic                 busy,
   output logic                 done,
   output logic                 game_over
);

   localparam int         W        = 8*MAX_LEN;
   localparam int         IW       = $clog2(W);
   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

   function automatic logic [W-1:0] init_snake();
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < INIT_LEN; k++) v[8*k +: 8] = {INIT_Y, INIT_X - 4'(k)};
      return v;
   endfunction

   state_t       r_state;
   logic [W-1:0] r_snake;
   logic [7:0]   r_len;
   logic [1:0]   r_dir;
   logic         r_grow;
   logic [7:0]   r_new_head;
   logic [7:0]   r_idx;
   logic         r_busy;
   logic         r_done;
   logic         r_over;

   logic [1:0]   w_eff_dir;
   logic [3:0]   w_nx;
   logic [3:0]   w_ny;
   logic [IW-1:0] w_seg_base;
   logic [7:0]   w_seg;
   logic [7:0]   w_last;
   logic [7:0]   w_new_len;
   logic [W-1:0] w_shifted;

   // A request that exactly reverses the current heading keeps the current heading.
   assign w_eff_dir = (dir == (r_dir ^ 2'b10)) ? r_dir : dir;

   always_comb begin
      w_nx = r_snake[3:0];
      w_ny = r_snake[7:4];
      case (w_eff_dir)
         2'b00:   w_ny = r_snake[7:4] - 4'd1;
         2'b01:   w_nx = r_snake[3:0] + 4'd1;
         2'b10:   w_ny = r_snake[7:4] + 4'd1;
         default: w_nx = r_snake[3:0] - 4'd1;
      endcase
   end

   assign w_seg_base = IW'({r_idx, 3'b000});
   assign w_seg      = r_snake[w_seg_base +: 8];
   // Without growth the tail cell is vacated this move, so it is not scanned.
   assign w_last     = r_grow ? (r_len - 8'd1) : (r_len - 8'd2);
   assign w_new_len  = (r_grow && (r_len < MAX_LEN8)) ? (r_len + 8'd1) : r_len;

   always_comb begin
      w_shifted = {r_snake[W-9:0], r_new_head};
      for (int k = 0; k < MAX_LEN; k++)
         if (k >= int'(w_new_len)) w_shifted[8*k +: 8] = 8'h00;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_snake    <= init_snake();
         r_len      <= 8'(INIT_LEN);
         r_dir      <= 2'b01;
         r_grow     <= 1'b0;
         r_new_head <= 8'h00;
         r_idx      <= 8'h00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_over     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (step && !r_over) begin
                  r_dir      <= w_eff_dir;
                  r_grow     <= grow;
                  r_new_head <= {w_ny, w_nx};
                  r_idx      <= 8'h00;
                  r_busy     <= 1'b1;
                  r_state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_seg == r_new_head) begin
                  r_over  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_idx == w_last) begin
                  r_state <= S_SHIFT;
               end else begin
                  r_idx <= r_idx + 8'd1;
               end
            end
            S_SHIFT: begin
               r_snake <= w_shifted;
               r_len   <= w_new_len;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign snake_out = r_snake;
   assign length    = r_len;
   assign head_x    = r_snake[3:0];
   assign head_y    = r_snake[7:4];
   assign busy      = r_busy;
   assign done      = r_done;
   assign game_over = r_over;

endmodule

// File: tb/tb_snake_body.sv
// tb/tb_snake_body.sv - randomized and directed bench for snake_body against a queue model
module tb_snake_body;
   localparam int ML = 225;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            step = 1'b0;
   logic [1:0]      dir = 2'b00;
   logic            grow = 1'b0;
   logic [8*ML-1:0] snake_out;
   logic [7:0]      length;
   logic [3:0]      head_x;
   logic [3:0]      head_y;
   logic            busy;
   logic            done;
   logic            game_over;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_snake[$];
   int         m_dir;
   bit         m_over;

   always #5 clk = ~clk;

   snake_body dut (
      .clk(clk), .reset_n(reset_n), .step(step), .dir(dir), .grow(grow),
      .snake_out(snake_out), .length(length), .head_x(head_x), .head_y(head_y),
      .busy(busy), .done(done), .game_over(game_over)
   );

   function automatic logic [8*ML-1:0] model_vec();
      logic [8*ML-1:0] v;
      v = '0;
      foreach (m_snake[i]) v[8*i +: 8] = m_snake[i];
      return v;
   endfunction

   task automatic model_reset();
      m_snake = {};
      for (int k = 0; k < 3; k++) m_snake.push_back({4'd7, 4'(5 - k)});
      m_dir  = 1;
      m_over = 1'b0;
   endtask

   // Returns the expected step-to-done latency in cycles.
   task automatic model_move(input int d, input bit g, output int lat);
      int hx, hy, n, hit;
      logic [7:0] nh;
      if ((d + 2) % 4 != m_dir) m_dir = d;
      hx = int'(m_snake[0][3:0]);
      hy = int'(m_snake[0][7:4]);
      case (m_dir)
         0: hy = (hy + 15) % 16;
         1: hx = (hx + 1) % 16;
         2: hy = (hy + 1) % 16;
         default: hx = (hx + 15) % 16;
      endcase
      nh  = {4'(hy), 4'(hx)};
      n   = g ? m_snake.size() : m_snake.size() - 1;
      hit = -1;
      for (int i = 0; i < n; i++) if (hit < 0 && m_snake[i] == nh) hit = i;
      if (hit >= 0) begin
         m_over = 1'b1;
         lat    = hit + 2;
      end else begin
         m_snake.push_front(nh);
         if (!(g && m_snake.size() <= ML)) void'(m_snake.pop_back());
         lat = n + 2;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      step    = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic do_move(input logic [1:0] d, input logic g, output int lat);
      @(negedge clk);
      step = 1'b1; dir = d; grow = g;
      @(negedge clk);
      step = 1'b0; dir = 2'($urandom); grow = 1'($urandom);
      lat = 1;
      while (!done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (snake_out[23:0] !== 24'h737475) begin n_fail++; $display("FAIL reset_segs got %h want %h", snake_out[23:0], 24'h737475); end
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL reset_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      n_checks++; if (length !== 8'd3) begin n_fail++; $display("FAIL reset_len got %0d want 3", length); end
      n_checks++; if ({head_y, head_x} !== 8'h75) begin n_fail++; $display("FAIL reset_head got %h want 75", {head_y, head_x}); end
      n_checks++; if ({busy, done, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, game_over}); end
   endtask

   task automatic test_single_move();
      int lat, elat;
      model_move(1, 1'b0, elat);
      do_move(2'b01, 1'b0, lat);
      n_checks++; if (lat !== 4 || lat !== elat) begin n_fail++; $display("FAIL move_latency got %0d want %0d", lat, elat); end
      n_checks++; if (snake_out[31:0] !== 32'h00747576) begin n_fail++; $display("FAIL move_segs got %h want 00747576", snake_out[31:0]); end
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL move_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      n_checks++; if (length !== 8'd3) begin n_fail++; $display("FAIL move_len got %0d want 3", length); end
   endtask

   task automatic test_wrap();
      int lat, elat;
      while (m_snake[0][3:0] != 4'd15) begin
         model_move(1, 1'b0, elat);
         do_move(2'b01, 1'b0, lat);
         n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL wrap_walk got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      end
      model_move(1, 1'b0, elat);
      do_move(2'b01, 1'b0, lat);
      n_checks++; if ({head_y, head_x} !== 8'h70) begin n_fail++; $display("FAIL wrap_head got %h want 70", {head_y, head_x}); end
      n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL wrap_over got %b want 0", game_over); end
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL wrap_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
   endtask

   task automatic test_reversal();
      int lat, elat;
      apply_reset();
      model_move(3, 1'b0, elat);
      do_move(2'b11, 1'b0, lat);
      n_checks++; if ({head_y, head_x} !== 8'h76) begin n_fail++; $display("FAIL reversal_head got %h want 76", {head_y, head_x}); end
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL reversal_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
   endtask

   task automatic test_growth();
      int lat, elat;
      apply_reset();
      model_move(0, 1'b1, elat);
      do_move(2'b00, 1'b1, lat);
      n_checks++; if (length !== 8'd4) begin n_fail++; $display("FAIL grow_len got %0d want 4", length); end
      n_checks++; if (snake_out[39:0] !== 40'h0073747565) begin n_fail++; $display("FAIL grow_segs got %h want 0073747565", snake_out[39:0]); end
      n_checks++; if (lat !== 5 || lat !== elat) begin n_fail++; $display("FAIL grow_latency got %0d want %0d", lat, elat); end
   endtask

   task automatic test_back_to_back();
      int lat, elat, seen;
      apply_reset();
      model_move(0, 1'b0, elat);
      @(negedge clk); step = 1'b1; dir = 2'b00; grow = 1'b0;
      @(negedge clk); step = 1'b1; dir = 2'b01; grow = 1'b1; lat = 1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
      @(negedge clk); step = 1'b0; lat = 2;
      while (!done && lat < 400) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, elat); end
      n_checks++; if (snake_out !== model_vec() || length !== 8'(m_snake.size())) begin n_fail++; $display("FAIL b2b_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      seen = 0;
      repeat (6) begin @(negedge clk); if (busy || done) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL b2b_dropped got %0d active cycles want 0", seen); end
   endtask

   task automatic test_collision();
      int lat, elat, seen;
      logic [1:0] dseq[5] = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b10};
      bit         gseq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         model_move(int'(dseq[i]), gseq[i], elat);
         do_move(dseq[i], gseq[i], lat);
         n_checks++; if (snake_out !== model_vec() || lat !== elat) begin n_fail++; $display("FAIL coll_move%0d got %h lat %0d want %h lat %0d", i, snake_out[63:0], lat, model_vec() & 64'hFFFF_FFFF_FFFF_FFFF, elat); end
      end
      n_checks++; if (game_over !== 1'b1 || !m_over) begin n_fail++; $display("FAIL coll_over got %b want 1", game_over); end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL coll_latency got %0d want 5", lat); end
      n_checks++; if (length !== 8'd5) begin n_fail++; $display("FAIL coll_len got %0d want 5", length); end
      @(negedge clk); step = 1'b1; dir = 2'b01;
      @(negedge clk); step = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (busy || done) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL coll_ignored got %0d active cycles want 0", seen); end
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL coll_frozen got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      apply_reset();
      n_checks++; if (game_over !== 1'b0 || snake_out !== model_vec()) begin n_fail++; $display("FAIL coll_reset got %b %h want 0 %h", game_over, snake_out[31:0], model_vec() & 32'hFFFF_FFFF); end
   endtask

   task automatic test_reset_mid_check();
      int lat, elat;
      apply_reset();
      model_move(2, 1'b0, elat);
      do_move(2'b10, 1'b0, lat);
      @(negedge clk); step = 1'b1; dir = 2'b01; grow = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (snake_out !== model_vec()) begin n_fail++; $display("FAIL midreset_vec got %h want %h", snake_out[63:0], model_vec() & 64'hFFFF_FFFF_FFFF_FFFF); end
      n_checks++; if (length !== 8'd3 || busy !== 1'b0 || done !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL midreset_state got len %0d busy %b done %b over %b want 3 0 0 0", length, busy, done, game_over); end
      @(negedge clk); reset_n = 1'b1;
      model_move(1, 1'b0, elat);
      do_move(2'b01, 1'b0, lat);
      n_checks++; if (snake_out !== model_vec() || lat !== elat) begin n_fail++; $display("FAIL midreset_after got %h lat %0d want %h lat %0d", snake_out[63:0], lat, model_vec() & 64'hFFFF_FFFF_FFFF_FFFF, elat); end
   endtask

   task automatic test_random();
      int lat, elat, d;
      bit g;
      apply_reset();
      for (int it = 0; it < 250; it++) begin
         d = int'($urandom_range(3));
         g = ($urandom_range(3) == 0);
         model_move(d, g, elat);
         do_move(2'(d), g, lat);
         n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rnd_latency it %0d got %0d want %0d", it, lat, elat); end
         n_checks++; if (snake_out !== model_vec() || length !== 8'(m_snake.size())) begin n_fail++; $display("FAIL rnd_vec it %0d got %h len %0d want %h len %0d", it, snake_out[63:0], length, model_vec() & 64'hFFFF_FFFF_FFFF_FFFF, m_snake.size()); end
         n_checks++; if ({head_y, head_x} !== m_snake[0] || game_over !== m_over) begin n_fail++; $display("FAIL rnd_head it %0d got %h over %b want %h over %b", it, {head_y, head_x}, game_over, m_snake[0], m_over); end
         if (m_over) apply_reset();
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_single_move();
      test_wrap();
      test_reversal();
      test_growth();
      test_back_to_back();
      test_collision();
      test_reset_mid_check();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
